alu_issue_seq: RTL and testbench

- Operand-supply and writeback side of the ALU interface. Accepts two-operand register instructions of the form rd <- rd OP rs over a valid/ready handshake.
- Holds the 16-entry register file and reads operands with forwarding. Drives the combinational ALU's com/a/b and writes y back to rd.
- Two-stage pipeline: decode/read (D) and execute/writeback (E). Sits between the instruction fetch and the ALU.

---
 rtl/alu_issue_seq_pkg.sv | 46 ++++
 rtl/alu_issue_seq_regfile.sv | 43 ++++
 rtl/alu_issue_seq.sv | 108 ++++++++++
 tb/tb_alu_issue_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue/writeback slice: widths, opcode
// constants, the legal-opcode check and the E-stage record.
package alu_issue_seq_pkg;

  localparam int WORD_SIZE = 32;
  localparam int OPCODE_W  = 8;
  localparam int NREG      = 16;
  localparam int RIDX_W    = $clog2(NREG);

  localparam logic [OPCODE_W-1:0] OP_NOP      = 8'h00;
  localparam logic [OPCODE_W-1:0] MOV_REG_REG = 8'h01;
  localparam logic [OPCODE_W-1:0] ADD_REG     = 8'h02;
  localparam logic [OPCODE_W-1:0] SUB_REG     = 8'h03;
  localparam logic [OPCODE_W-1:0] MUL_REG     = 8'h04;
  localparam logic [OPCODE_W-1:0] AND_REG     = 8'h05;
  localparam logic [OPCODE_W-1:0] ORR_REG     = 8'h06;
  localparam logic [OPCODE_W-1:0] XOR_REG     = 8'h07;

  // Contents of the execute/writeback stage register.
  typedef struct packed {
    logic                 valid;
    logic [OPCODE_W-1:0]  op;
    logic [RIDX_W-1:0]    rd;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
  } e_stage_t;

  // True for every opcode the ALU is allowed to execute and write back.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_NOP, MOV_REG_REG, ADD_REG, SUB_REG,
      MUL_REG, AND_REG, ORR_REG, XOR_REG: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when an instruction in E produces a register write.
  function automatic logic writes_reg(input logic [OPCODE_W-1:0] op,
                                      input logic [RIDX_W-1:0]   rd);
    return is_legal(op) && (op != OP_NOP) && (rd != '0);
  endfunction

endpackage

// File: rtl/alu_issue_seq_regfile.sv
// Register file: NREG words, two async operand read ports, an async debug
// port and one synchronous write port. r0 is hardwired to zero.
module alu_issue_seq_regfile
  import alu_issue_seq_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int DEPTH = NREG,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [0:DEPTH-1];

  // Synchronous reset clears every register; writes to r0 are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports see the stored value only; r0 always reads zero.
  always_comb begin
    ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Operand supply and writeback for an external combinational ALU.
// D stage reads rd/rs with forwarding from E; E stage drives the ALU and
// writes its result back into rd.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int WORD_SIZE = alu_issue_seq_pkg::WORD_SIZE,
  parameter int OP_W      = alu_issue_seq_pkg::OPCODE_W,
  parameter int NREG      = alu_issue_seq_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [3:0]           in_rd,
  input  logic [3:0]           in_rs,
  input  logic                 hold,
  output logic [OP_W-1:0]      alu_com,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic [WORD_SIZE-1:0] alu_y,
  output logic                 wb_valid,
  output logic [3:0]           wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 illegal_op,
  input  logic [3:0]           dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
);

  logic                 e_valid;
  logic [OP_W-1:0]      e_op;
  logic [3:0]           e_rd;
  logic [WORD_SIZE-1:0] e_a;
  logic [WORD_SIZE-1:0] e_b;

  logic [WORD_SIZE-1:0] rf_a;
  logic [WORD_SIZE-1:0] rf_b;
  logic [WORD_SIZE-1:0] opnd_a;
  logic [WORD_SIZE-1:0] opnd_b;
  logic                 e_writes;
  logic                 accept;

  alu_issue_seq_regfile #(
    .WIDTH (WORD_SIZE),
    .DEPTH (NREG),
    .AW    (4)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (in_rd),
    .ra_data  (rf_a),
    .rb_addr  (in_rs),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .waddr    (e_rd),
    .wdata    (alu_y)
  );

  // Handshake, writeback qualification and operand forwarding from E.
  always_comb begin
    in_ready   = !hold;
    accept     = in_valid && !hold;
    e_writes   = e_valid && writes_reg(e_op, e_rd);
    wb_valid   = e_writes && !hold;
    illegal_op = e_valid && !hold && !is_legal(e_op);
    wb_rd      = e_rd;
    wb_data    = alu_y;
    opnd_a     = rf_a;
    opnd_b     = rf_b;
    if (e_writes && (e_rd == in_rd)) begin
      opnd_a = alu_y;
    end
    if (e_writes && (e_rd == in_rs)) begin
      opnd_b = alu_y;
    end
  end

  // E-stage register: load on accept, drain when idle, freeze under hold.
  // Payload is kept on drain so the ALU inputs hold their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_op    <= '0;
      e_rd    <= '0;
      e_a     <= '0;
      e_b     <= '0;
    end else if (accept) begin
      e_valid <= 1'b1;
      e_op    <= in_op;
      e_rd    <= in_rd;
      e_a     <= opnd_a;
      e_b     <= opnd_b;
    end else if (!hold) begin
      e_valid <= 1'b0;
    end
  end

  // ALU inputs come straight from the E register.
  always_comb begin
    alu_com = e_op;
    alu_a   = e_a;
    alu_b   = e_b;
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural model of the external
// ALU. The ALU result can be overridden to seed registers with constants.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic        hold;
  logic [7:0]  alu_com;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_op;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        force_y;
  logic [31:0] force_val;

  int checks;
  int failures;

  alu_issue_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .hold       (hold),
    .alu_com    (alu_com),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .illegal_op (illegal_op),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // External ALU model, with an override used only for seeding constants.
  always_comb begin
    logic [31:0] prod;
    prod  = alu_a * alu_b;
    alu_y = 32'hx;
    case (alu_com)
      OP_NOP:      alu_y = 32'h0;
      MOV_REG_REG: alu_y = alu_b;
      ADD_REG:     alu_y = alu_a + alu_b;
      SUB_REG:     alu_y = alu_a - alu_b;
      MUL_REG:     alu_y = prod;
      AND_REG:     alu_y = alu_a & alu_b;
      ORR_REG:     alu_y = alu_a | alu_b;
      XOR_REG:     alu_y = alu_a ^ alu_b;
      default:     alu_y = 32'hx;
    endcase
    if (force_y) alu_y = force_val;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    checkOutput(tag, dbg_data, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one edge; it is then in E.
  task automatic applyStimulus(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs    = rs;
    step();
    in_valid = 1'b0;
    in_op    = OP_NOP;
  endtask

  // Load a constant into rd by forcing the ALU result of a MOV.
  task automatic seedReg(input logic [3:0] rd, input logic [31:0] val);
    force_y   = 1'b1;
    force_val = val;
    applyStimulus(MOV_REG_REG, rd, 4'd0);
    #1;
    checkOutput("seed_wb_valid", {31'b0, wb_valid}, 32'd1);
    step();
    force_y = 1'b0;
    checkReg("seed_value", rd, val);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    force_y   = 1'b0;
    force_val = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs     = '0;
    hold      = 1'b0;
    dbg_addr  = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst_illegal", {31'b0, illegal_op}, 32'd0);
    checkOutput("rst_alu_com", {24'b0, alu_com}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    for (int i = 0; i < 16; i++) checkReg("rst_reg", i[3:0], 32'd0);
    step();

    // MOV r1 <- r0
    applyStimulus(MOV_REG_REG, 4'd1, 4'd0);
    #1;
    checkOutput("mov_wb_valid", {31'b0, wb_valid}, 32'd1);
    checkOutput("mov_wb_rd", {28'b0, wb_rd}, 32'd1);
    checkOutput("mov_wb_data", wb_data, 32'd0);
    step();

    // Seed r3 = 5; debug port shows old value during the writeback cycle
    force_y   = 1'b1;
    force_val = 32'd5;
    applyStimulus(MOV_REG_REG, 4'd3, 4'd0);
    checkReg("dbg_pre_write", 4'd3, 32'd0);
    step();
    force_y = 1'b0;
    checkReg("seed_r3", 4'd3, 32'd5);

    // Back-to-back dependent chain on r2 relying on forwarding
    applyStimulus(XOR_REG, 4'd2, 4'd2);
    checkOutput("xor_alu_a", alu_a, 32'd0);
    applyStimulus(ADD_REG, 4'd2, 4'd3);
    checkOutput("add1_alu_b", alu_b, 32'd5);
    checkOutput("add1_wb_data", wb_data, 32'd5);
    applyStimulus(ADD_REG, 4'd2, 4'd2);
    checkOutput("add2_alu_a", alu_a, 32'd5);
    checkOutput("add2_alu_b", alu_b, 32'd5);
    applyStimulus(ADD_REG, 4'd2, 4'd2);
    checkOutput("add3_alu_a", alu_a, 32'd10);
    checkOutput("add3_wb_data", wb_data, 32'd20);
    step();
    checkReg("chain_r2", 4'd2, 32'd20);

    // SUB underflow wraps
    seedReg(4'd5, 32'd1);
    applyStimulus(SUB_REG, 4'd4, 4'd5);
    checkOutput("sub_wb_data", wb_data, 32'hFFFF_FFFF);
    step();
    checkReg("sub_r4", 4'd4, 32'hFFFF_FFFF);

    // MUL keeps the low word
    seedReg(4'd6, 32'h0001_0000);
    applyStimulus(MUL_REG, 4'd6, 4'd6);
    checkOutput("mul_wb_valid", {31'b0, wb_valid}, 32'd1);
    step();
    checkReg("mul_r6", 4'd6, 32'd0);

    // Unknown opcode: one cycle of illegal_op, nothing written
    applyStimulus(8'hFF, 4'd2, 4'd3);
    checkOutput("ill_flag", {31'b0, illegal_op}, 32'd1);
    checkOutput("ill_wb_valid", {31'b0, wb_valid}, 32'd0);
    step();
    checkOutput("ill_flag_drop", {31'b0, illegal_op}, 32'd0);
    checkReg("ill_r2", 4'd2, 32'd20);
    checkReg("ill_r3", 4'd3, 32'd5);

    // Write to r0 is dropped
    applyStimulus(ADD_REG, 4'd0, 4'd3);
    checkOutput("r0_wb_valid", {31'b0, wb_valid}, 32'd0);
    step();
    checkReg("r0_value", 4'd0, 32'd0);

    // Hold for three edges with an ADD in E and another offered
    applyStimulus(ADD_REG, 4'd7, 4'd3);
    hold     = 1'b1;
    in_valid = 1'b1;
    in_op    = ADD_REG;
    in_rd    = 4'd8;
    in_rs    = 4'd3;
    #1;
    checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("hold_wb_valid", {31'b0, wb_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("hold_alu_com", {24'b0, alu_com}, {24'b0, ADD_REG});
      checkOutput("hold_alu_b", alu_b, 32'd5);
      checkOutput("hold_wb_valid_n", {31'b0, wb_valid}, 32'd0);
      checkReg("hold_r7", 4'd7, 32'd0);
    end
    hold     = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rel_wb_valid", {31'b0, wb_valid}, 32'd1);
    checkOutput("rel_wb_data", wb_data, 32'd5);
    step();
    checkReg("rel_r7", 4'd7, 32'd5);
    checkReg("rel_r8", 4'd8, 32'd0);
    checkOutput("rel_idle_wb", {31'b0, wb_valid}, 32'd0);

    // Reset with an ADD in E and another instruction offered
    applyStimulus(ADD_REG, 4'd9, 4'd3);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_op    = ADD_REG;
    in_rd    = 4'd10;
    in_rs    = 4'd3;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("mid_rst_wb", {31'b0, wb_valid}, 32'd0);
    checkOutput("mid_rst_com", {24'b0, alu_com}, 32'd0);
    checkOutput("mid_rst_a", alu_a, 32'd0);
    for (int i = 0; i < 16; i++) checkReg("mid_rst_reg", i[3:0], 32'd0);
    step();

    // Normal operation after reset
    seedReg(4'd11, 32'd7);
    applyStimulus(ADD_REG, 4'd11, 4'd11);
    checkOutput("post_rst_wb", wb_data, 32'd14);
    step();
    checkReg("post_rst_r11", 4'd11, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
